// File: rtl/uart_tx_buffered.sv
// UART transmitter, 8N1 by default, LSB first, with a one-byte holding
// register so a queued byte starts right after the previous stop bit.
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 2604,
  parameter int DBIT         = 8,
  parameter int SB_BITS      = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx_ready,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic            tx
);

  localparam int BW   = $clog2(CLKS_PER_BIT);
  localparam int NMAX = (DBIT > SB_BITS) ? DBIT : SB_BITS;
  localparam int NW   = (NMAX > 1) ? $clog2(NMAX) : 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [NW-1:0] DATA_LAST = NW'(DBIT - 1);
  localparam logic [NW-1:0] STOP_LAST = NW'(SB_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_n;
  logic [BW-1:0]   baud, baud_n;
  logic [NW-1:0]   nbit, nbit_n;
  logic [DBIT-1:0] shifter, shifter_n;
  logic [DBIT-1:0] hold, hold_n;
  logic            hold_valid, hold_valid_n;
  logic            tx_n;
  logic            baud_end;
  logic            frame_end;
  logic            accept;

  assign baud_end  = (baud == BAUD_LAST);
  assign frame_end = (state == STOP) && baud_end && (nbit == STOP_LAST);
  assign accept    = tx_start && !hold_valid;

  assign tx_ready     = !hold_valid;
  assign tx_busy      = (state != IDLE);
  assign tx_done_tick = frame_end;

  // State, counters, datapath and the registered serial line
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      baud       <= '0;
      nbit       <= '0;
      shifter    <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      tx         <= 1'b1;
    end else begin
      state      <= state_n;
      baud       <= baud_n;
      nbit       <= nbit_n;
      shifter    <= shifter_n;
      hold       <= hold_n;
      hold_valid <= hold_valid_n;
      tx         <= tx_n;
    end
  end

  // Next-state, bit timing, holding-register handoff and next line level
  always_comb begin
    state_n      = state;
    baud_n       = baud;
    nbit_n       = nbit;
    shifter_n    = shifter;
    hold_n       = hold;
    hold_valid_n = hold_valid;

    case (state)
      IDLE: begin
        if (accept) begin
          shifter_n = din;
          state_n   = START;
          baud_n    = '0;
          nbit_n    = '0;
        end
      end
      START: begin
        if (baud_end) begin
          state_n = DATA;
          baud_n  = '0;
          nbit_n  = '0;
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_n    = '0;
          shifter_n = shifter >> 1;
          if (nbit == DATA_LAST) begin
            state_n = STOP;
            nbit_n  = '0;
          end else begin
            nbit_n = nbit + NW'(1);
          end
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_n = '0;
          if (nbit == STOP_LAST) begin
            nbit_n = '0;
            // A byte offered on the final stop cycle with holding empty
            // goes straight to the shifter instead of through holding.
            if (hold_valid) begin
              shifter_n    = hold;
              hold_valid_n = 1'b0;
              state_n      = START;
            end else if (accept) begin
              shifter_n = din;
              state_n   = START;
            end else begin
              state_n = IDLE;
            end
          end else begin
            nbit_n = nbit + NW'(1);
          end
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    if (accept && (state != IDLE) && !frame_end) begin
      hold_n       = din;
      hold_valid_n = 1'b1;
    end

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shifter_n[0];
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Testbench for uart_tx_buffered: frame-level reference model plus a line decoder.
module tb_uart_tx_buffered;

  localparam int CPB = 4;
  localparam int NB  = 8;
  localparam int FL  = (1 + NB + 1) * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_start;
  logic [7:0] din;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done_tick;
  logic       tx;

  int total = 0;
  int bad   = 0;

  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .DBIT(NB), .SB_BITS(1)) dut (
    .clk(clk), .reset(reset), .tx_start(tx_start), .din(din),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick), .tx(tx)
  );

  always #5 clk = ~clk;

  // Reference model: the frame in flight is described by its first cycle and byte.
  int         now    = 0;
  bit         m_act  = 0;
  int         m_start = 0;
  logic [7:0] m_byte = '0;
  bit         m_qv   = 0;
  logic [7:0] m_qb   = '0;
  logic [7:0] m_sent[$];

  // Line decoder: samples mid-bit.
  bit         d_act  = 0;
  int         d_c    = 0;
  logic [7:0] d_byte = '0;
  logic [7:0] d_got[$];

  // Expected {tx, tx_ready, tx_busy, tx_done_tick} for the current cycle
  function automatic logic [3:0] exp_out();
    logic etx;
    int   k;
    etx = 1'b1;
    if (m_act) begin
      k = (now - m_start) / CPB;
      if (k == 0) etx = 1'b0;
      else if (k <= NB) etx = m_byte[k-1];
    end
    return {etx, !m_qv, m_act, m_act && (now == m_start + FL - 1)};
  endfunction

  task automatic tick(input bit st, input logic [7:0] d, input bit rst);
    bit last, acc;
    tx_start = st;
    din      = d;
    reset    = rst;
    @(posedge clk);
    last = m_act && (now == m_start + FL - 1);
    acc  = st && !m_qv;
    if (rst) begin
      m_act = 0;
      m_qv  = 0;
    end else if (!m_act) begin
      if (acc) begin
        m_act = 1; m_start = now + 1; m_byte = d; m_sent.push_back(d);
      end
    end else if (last) begin
      if (m_qv) begin
        m_start = now + 1; m_byte = m_qb; m_qv = 0; m_sent.push_back(m_qb);
      end else if (acc) begin
        m_start = now + 1; m_byte = d; m_sent.push_back(d);
      end else begin
        m_act = 0;
      end
    end else if (acc) begin
      m_qv = 1;
      m_qb = d;
    end
    now++;
    #1;
    if (rst) begin
      d_act = 0;
    end else if (!d_act) begin
      if (tx === 1'b0) begin
        d_act = 1;
        d_c   = 0;
      end
    end else begin
      d_c++;
      if (d_c >= CPB && d_c < (1 + NB) * CPB && (d_c % CPB) == CPB / 2)
        d_byte[d_c / CPB - 1] = tx;
      else if (d_c == (1 + NB) * CPB + CPB / 2) begin
        d_got.push_back(d_byte);
        d_act = 0;
      end
    end
    tx_start = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 22; i++) begin
      tick(1'b0, 8'($urandom), i < 2);
      if (i >= 1) begin
        total++;
        if ({tx, tx_ready, tx_busy, tx_done_tick} !== exp_out()) begin
          bad++;
          $display("FAIL reset_idle t=%0d got=%b exp=%b", now, {tx, tx_ready, tx_busy, tx_done_tick}, exp_out());
        end
      end
    end
  endtask

  task automatic test_single();
    int done_n = 0, done_at = -1, busy_n = 0;
    d_got.delete(); m_sent.delete();
    for (int i = 0; i < 46; i++) begin
      tick(i == 0, (i == 0) ? 8'hA5 : 8'($urandom), 1'b0);
      total++;
      if ({tx, tx_ready, tx_busy, tx_done_tick} !== exp_out()) begin
        bad++;
        $display("FAIL single_a5 t=%0d got=%b exp=%b", now, {tx, tx_ready, tx_busy, tx_done_tick}, exp_out());
      end
      if (tx_done_tick === 1'b1) begin done_n++; done_at = i; end
      if (tx_busy === 1'b1) busy_n++;
    end
    total++;
    if (done_n != 1 || done_at != 39 || busy_n != 40) begin
      bad++;
      $display("FAIL single_timing got done_n=%0d done_at=%0d busy=%0d exp 1/39/40", done_n, done_at, busy_n);
    end
    total++;
    if (d_got.size() != 1 || d_got[0] !== 8'hA5) begin
      bad++;
      $display("FAIL single_decode got n=%0d first=%h exp 1 byte a5", d_got.size(), (d_got.size() > 0) ? d_got[0] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back();
    int dones[$];
    d_got.delete(); m_sent.delete();
    for (int i = 0; i < 90; i++) begin
      tick(i == 0 || i == 10, (i == 0) ? 8'h55 : (i == 10) ? 8'hC3 : 8'($urandom), 1'b0);
      total++;
      if ({tx, tx_ready, tx_busy, tx_done_tick} !== exp_out()) begin
        bad++;
        $display("FAIL b2b t=%0d got=%b exp=%b", now, {tx, tx_ready, tx_busy, tx_done_tick}, exp_out());
      end
      if (tx_done_tick === 1'b1) dones.push_back(i);
      if (i == 10) begin
        total++;
        if (tx_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_drop got=%b exp=0", tx_ready); end
      end
      if (i == 40) begin
        total++;
        if (tx !== 1'b0 || tx_ready !== 1'b1) begin
          bad++; $display("FAIL b2b_no_gap got tx=%b ready=%b exp tx=0 ready=1", tx, tx_ready);
        end
      end
    end
    total++;
    if (dones.size() != 2 || dones[1] - dones[0] != FL) begin
      bad++;
      $display("FAIL b2b_done_spacing got n=%0d exp 2 ticks %0d apart", dones.size(), FL);
    end
    total++;
    if (d_got.size() != 2 || d_got[0] !== 8'h55 || d_got[1] !== 8'hC3) begin
      bad++; $display("FAIL b2b_decode got n=%0d exp 55,c3", d_got.size());
    end
  endtask

  task automatic test_overrun();
    bit st;
    logic [7:0] d;
    d_got.delete(); m_sent.delete();
    for (int i = 0; i < 95; i++) begin
      st = 1'b0; d = 8'($urandom);
      if (i == 0) begin st = 1'b1; d = 8'h01; end
      if (i == 3) begin st = 1'b1; d = 8'h02; end
      if (i == 8 || i == 20) begin st = 1'b1; d = 8'hFF; end
      tick(st, d, 1'b0);
      total++;
      if ({tx, tx_ready, tx_busy, tx_done_tick} !== exp_out()) begin
        bad++;
        $display("FAIL overrun t=%0d got=%b exp=%b", now, {tx, tx_ready, tx_busy, tx_done_tick}, exp_out());
      end
    end
    total++;
    if (d_got.size() != 2 || d_got[0] !== 8'h01 || d_got[1] !== 8'h02) begin
      bad++; $display("FAIL overrun_decode got n=%0d exp 01,02", d_got.size());
    end
  endtask

  task automatic test_boundary();
    bit st, prev_done;
    logic [7:0] d;
    int ndone;
    ndone = 0; prev_done = 0;
    d_got.delete(); m_sent.delete();
    for (int i = 0; i < 170; i++) begin
      st = 1'b0; d = 8'($urandom);
      if (i == 0) begin st = 1'b1; d = 8'h00; end
      else if (prev_done && ndone == 1) begin st = 1'b1; d = 8'h7E; end
      else if (i == 120) begin st = 1'b1; d = 8'hFF; end
      tick(st, d, 1'b0);
      total++;
      if ({tx, tx_ready, tx_busy, tx_done_tick} !== exp_out()) begin
        bad++;
        $display("FAIL boundary t=%0d got=%b exp=%b", now, {tx, tx_ready, tx_busy, tx_done_tick}, exp_out());
      end
      if (i == 40) begin
        total++;
        if (tx !== 1'b0 || tx_ready !== 1'b1 || tx_busy !== 1'b1) begin
          bad++; $display("FAIL boundary_no_gap got tx=%b ready=%b busy=%b exp 0/1/1", tx, tx_ready, tx_busy);
        end
      end
      prev_done = (tx_done_tick === 1'b1);
      if (prev_done) ndone++;
    end
    total++;
    if (ndone != 3 || d_got.size() != 3 || d_got[0] !== 8'h00 || d_got[1] !== 8'h7E || d_got[2] !== 8'hFF) begin
      bad++; $display("FAIL boundary_decode got dones=%0d n=%0d exp 3 frames 00,7e,ff", ndone, d_got.size());
    end
  endtask

  task automatic test_reset_mid();
    bit st;
    logic [7:0] d;
    int late_done;
    late_done = 0;
    d_got.delete(); m_sent.delete();
    for (int i = 0; i < 105; i++) begin
      st = 1'b0; d = 8'($urandom);
      if (i == 0) begin st = 1'b1; d = 8'h0F; end
      if (i == 2) begin st = 1'b1; d = 8'hF0; end
      if (i == 60) begin st = 1'b1; d = 8'h3C; end
      tick(st, d, i == 17);
      total++;
      if ({tx, tx_ready, tx_busy, tx_done_tick} !== exp_out()) begin
        bad++;
        $display("FAIL reset_mid t=%0d got=%b exp=%b", now, {tx, tx_ready, tx_busy, tx_done_tick}, exp_out());
      end
      if (i == 17) begin
        total++;
        if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done_tick !== 1'b0) begin
          bad++; $display("FAIL reset_mid_clear got tx=%b ready=%b busy=%b done=%b exp 1/1/0/0", tx, tx_ready, tx_busy, tx_done_tick);
        end
      end
      if (i > 17 && i < 60 && (tx_done_tick !== 1'b0 || tx !== 1'b1)) late_done++;
    end
    total++;
    if (late_done != 0) begin bad++; $display("FAIL reset_mid_idle got %0d active cycles exp 0", late_done); end
    total++;
    if (d_got.size() != 1 || d_got[0] !== 8'h3C) begin
      bad++; $display("FAIL reset_mid_decode got n=%0d exp single 3c", d_got.size());
    end
  endtask

  task automatic test_din_stability();
    d_got.delete(); m_sent.delete();
    for (int i = 0; i < 45; i++) begin
      tick(i == 0, (i == 0) ? 8'h96 : 8'($urandom), 1'b0);
      total++;
      if ({tx, tx_ready, tx_busy, tx_done_tick} !== exp_out()) begin
        bad++;
        $display("FAIL din_stab t=%0d got=%b exp=%b", now, {tx, tx_ready, tx_busy, tx_done_tick}, exp_out());
      end
    end
    total++;
    if (d_got.size() != 1 || d_got[0] !== 8'h96) begin
      bad++; $display("FAIL din_stab_decode got n=%0d exp single 96", d_got.size());
    end
  endtask

  task automatic test_random();
    d_got.delete(); m_sent.delete();
    for (int i = 0; i < 1500; i++) begin
      tick((i < 1400) && ($urandom_range(0, 7) == 0), 8'($urandom), 1'b0);
      total++;
      if ({tx, tx_ready, tx_busy, tx_done_tick} !== exp_out()) begin
        bad++;
        $display("FAIL random t=%0d got=%b exp=%b", now, {tx, tx_ready, tx_busy, tx_done_tick}, exp_out());
      end
    end
    total++;
    if (d_got.size() != m_sent.size() || m_sent.size() == 0) begin
      bad++; $display("FAIL random_count got=%0d exp=%0d", d_got.size(), m_sent.size());
    end else begin
      foreach (m_sent[k]) begin
        total++;
        if (d_got[k] !== m_sent[k]) begin
          bad++; $display("FAIL random_byte idx=%0d got=%h exp=%h", k, d_got[k], m_sent[k]);
        end
      end
    end
  endtask

  initial begin
    tx_start = 1'b0;
    din      = '0;
    reset    = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_boundary();
    test_reset_mid();
    test_din_stability();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
